apb_mst_arb2: RTL and testbench
===============================

APB_MST_ARB2 -- requirements
Module: apb_mst_arb2

Interface
REQ-001 SHALL have parameter PADDR_SIZE, default 10, APB address width.
REQ-002 SHALL have parameter PDATA_SIZE, default 8, APB data width (multiple of 8).
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS-phase cycles (used only with APB_MST_ARB2_TIMEOUT_EN).
REQ-004 SHALL have one clock PCLK and reset PRESETn, asynchronous, active-low: PCLK  in  1  clock; PRESETn  in  1  async active-low reset.
REQ-005 SHALL have requester-side ports, index i in {0,1}: S_PSEL in 2 select; S_PENABLE in 2 enable (ignored); S_PPROT in 2x3; S_PWRITE in 2; S_PSTRB in 2x(PDATA_SIZE/8); S_PADDR in 2xPADDR_SIZE; S_PWDATA in 2xPDATA_SIZE.
REQ-006 SHALL have requester responses: S_PREADY out 2 per-requester completion; S_PSLVERR out 2 per-requester error; S_PRDATA out PDATA_SIZE shared read data.
REQ-007 SHALL have downstream APB master ports: PSEL, PENABLE, PWRITE out 1; PPROT out 3; PSTRB out PDATA_SIZE/8; PADDR out PADDR_SIZE; PWDATA out PDATA_SIZE; PRDATA in PDATA_SIZE; PREADY, PSLVERR in 1.
REQ-008 SHALL have GNT out 2, one-hot current grant, 0 when idle.

Function
REQ-009 SHALL arbitrate two APB requesters onto one APB slave bus, all outputs registered.
REQ-010 SHALL use FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
REQ-011 In IDLE, any S_PSEL[i]=1 SHALL be granted: GNT set, requester PADDR/PWRITE/PWDATA/PSTRB/PPROT captured into downstream outputs, PSEL<=1, PENABLE<=0, go SETUP.
REQ-012 When both S_PSEL are high in IDLE, the requester not granted last SHALL win (round-robin); a single requester SHALL win regardless of pointer.
REQ-013 SETUP SHALL last exactly one cycle: PENABLE<=1, go ACCESS; captured signals held stable.
REQ-014 In ACCESS with PREADY=1: PSEL<=0, PENABLE<=0, S_PREADY[g]<=1, S_PSLVERR[g]<=PSLVERR, S_PRDATA<=PRDATA, update round-robin pointer to g, go DONE.
REQ-015 In ACCESS with PREADY=0, state and all outputs SHALL hold.
REQ-016 DONE SHALL last one cycle; S_PREADY, S_PSLVERR, GNT cleared on exit; no arbitration in DONE, so the completing requester's stale PSEL is never re-granted.
REQ-017 Latency: S_PSEL sampled at edge N yields PSEL at N+1, PENABLE at N+2, S_PREADY at N+3 when PREADY=1 in ACCESS; minimum 4 cycles per transfer.
REQ-018 S_PREADY of a non-granted requester SHALL remain 0; its request waits (APB wait state) with no loss.
REQ-019 S_PRDATA SHALL hold last captured value; valid only while S_PREADY[i]=1.
REQ-020 Requester inputs changing during a granted transfer SHALL have no effect on downstream outputs.

Reset
REQ-021 PRESETn low SHALL immediately force FSM=IDLE, round-robin pointer=1 (requester 0 wins first tie), and every output (PSEL, PENABLE, PWRITE, PPROT, PSTRB, PADDR, PWDATA, S_PREADY, S_PSLVERR, S_PRDATA, GNT) to 0, including mid-transfer.
REQ-022 The first IDLE arbitration SHALL occur on the first PCLK edge after PRESETn deasserts.

Configuration
REQ-023 Macro APB_MST_ARB2_TIMEOUT_EN defined: a counter SHALL run in ACCESS; after TIMEOUT cycles without PREADY, transfer SHALL terminate as in REQ-014 with S_PSLVERR[g]=1, S_PRDATA=0.
REQ-024 Macro undefined: no counter is built; ACCESS waits for PREADY indefinitely; TIMEOUT unused.

Verification
REQ-025 Req0 write PADDR=0x012 PWDATA=0xA5 PSTRB=1, PREADY=1 -> PSEL at N+1, PENABLE at N+2, S_PREADY[0]=1 at N+3, GNT=01, S_PSLVERR[0]=0.
REQ-026 Both requesters held after reset -> req0 served first, then req1, then req0; GNT sequence 01,10,01; S_PREADY[1] never asserts during req0 transfer.
REQ-027 Req1 read, PREADY low 3 ACCESS cycles then high with PRDATA=0x3C, PSLVERR=1 -> S_PRDATA=0x3C, S_PSLVERR[1]=1, S_PREADY[1]=1 for exactly one cycle.
REQ-028 PREADY stuck 0, TIMEOUT=16 -> with macro: PSEL drops and S_PREADY[0]=1, S_PSLVERR[0]=1 after 16 ACCESS cycles; without macro: PSEL/PENABLE remain 1 after 100 cycles.
REQ-029 PRESETn asserted in ACCESS -> all outputs 0 same cycle; after release with both requesting, req0 granted first.

Source files
------------

// File: rtl/apb_mst_arb2_if.sv
// Bus bundle for apb_mst_arb2: two requester-side APB ports, the shared downstream
// APB master port and the grant vector. "master" is the arbiter's view, "slave" the environment's.
`timescale 1ns/1ps
interface apb_mst_arb2_if #(
    parameter int PADDR_SIZE = 10,
    parameter int PDATA_SIZE = 8
);
    localparam int PSTRB_SIZE = PDATA_SIZE / 8;

    // Requester side, index i in {0,1}
    logic [1:0]                 S_PSEL;
    logic [1:0]                 S_PENABLE;
    logic [1:0][2:0]            S_PPROT;
    logic [1:0]                 S_PWRITE;
    logic [1:0][PSTRB_SIZE-1:0] S_PSTRB;
    logic [1:0][PADDR_SIZE-1:0] S_PADDR;
    logic [1:0][PDATA_SIZE-1:0] S_PWDATA;
    logic [1:0]                 S_PREADY;
    logic [1:0]                 S_PSLVERR;
    logic [PDATA_SIZE-1:0]      S_PRDATA;

    // Downstream APB master
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [2:0]                 PPROT;
    logic [PSTRB_SIZE-1:0]      PSTRB;
    logic [PADDR_SIZE-1:0]      PADDR;
    logic [PDATA_SIZE-1:0]      PWDATA;
    logic [PDATA_SIZE-1:0]      PRDATA;
    logic                       PREADY;
    logic                       PSLVERR;

    logic [1:0]                 GNT;

    modport master (
        input  S_PSEL, S_PENABLE, S_PPROT, S_PWRITE, S_PSTRB, S_PADDR, S_PWDATA,
        output S_PREADY, S_PSLVERR, S_PRDATA,
        output PSEL, PENABLE, PWRITE, PPROT, PSTRB, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR,
        output GNT
    );

    modport slave (
        output S_PSEL, S_PENABLE, S_PPROT, S_PWRITE, S_PSTRB, S_PADDR, S_PWDATA,
        input  S_PREADY, S_PSLVERR, S_PRDATA,
        input  PSEL, PENABLE, PWRITE, PPROT, PSTRB, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR,
        input  GNT
    );
endinterface

// File: rtl/apb_mst_arb2.sv
// Two-requester round-robin APB arbiter driving one APB slave; every output is registered.
// Optional ACCESS-phase watchdog enabled by defining APB_MST_ARB2_TIMEOUT_EN.
`timescale 1ns/1ps
module apb_mst_arb2 #(
    parameter int PADDR_SIZE = 10,
    parameter int PDATA_SIZE = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic           PCLK,
    input  logic           PRESETn,
    apb_mst_arb2_if.master bus
);
    localparam int PSTRB_SIZE = PDATA_SIZE / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_q, last_d;
    logic [1:0]             gnt_q, gnt_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [2:0]             pprot_q, pprot_d;
    logic [PSTRB_SIZE-1:0]  pstrb_q, pstrb_d;
    logic [PADDR_SIZE-1:0]  paddr_q, paddr_d;
    logic [PDATA_SIZE-1:0]  pwdata_q, pwdata_d;
    logic [1:0]             sready_q, sready_d;
    logic [1:0]             sslverr_q, sslverr_d;
    logic [PDATA_SIZE-1:0]  sprdata_q, sprdata_d;

    // Winner: the lone requester, or on a tie the one not served last.
    logic sel;
    assign sel = bus.S_PSEL[1] & (~bus.S_PSEL[0] | ~last_q);

    // Requester PENABLE carries no information for this arbiter.
    logic unused_penable;
    assign unused_penable = ^bus.S_PENABLE;

`ifdef APB_MST_ARB2_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            gnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pprot_q   <= '0;
            pstrb_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            sready_q  <= '0;
            sslverr_q <= '0;
            sprdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pprot_q   <= pprot_d;
            pstrb_q   <= pstrb_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            sready_q  <= sready_d;
            sslverr_q <= sslverr_d;
            sprdata_q <= sprdata_d;
        end
    end

`ifdef APB_MST_ARB2_TIMEOUT_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`endif

    logic                  cmpl;
    logic                  cmpl_err;
    logic [PDATA_SIZE-1:0] cmpl_data;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        pprot_d   = pprot_q;
        pstrb_d   = pstrb_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        sready_d  = sready_q;
        sslverr_d = sslverr_q;
        sprdata_d = sprdata_q;
        cmpl      = 1'b0;
        cmpl_err  = 1'b0;
        cmpl_data = '0;
`ifdef APB_MST_ARB2_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|bus.S_PSEL) begin
                    gnt_d     = sel ? 2'b10 : 2'b01;
                    paddr_d   = bus.S_PADDR[sel];
                    pwrite_d  = bus.S_PWRITE[sel];
                    pwdata_d  = bus.S_PWDATA[sel];
                    pstrb_d   = bus.S_PSTRB[sel];
                    pprot_d   = bus.S_PPROT[sel];
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB_MST_ARB2_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ST_ACCESS: begin
                if (bus.PREADY) begin
                    cmpl      = 1'b1;
                    cmpl_err  = bus.PSLVERR;
                    cmpl_data = bus.PRDATA;
                end
`ifdef APB_MST_ARB2_TIMEOUT_EN
                // Watchdog: the TIMEOUT-th stalled ACCESS cycle ends the transfer with an error.
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cmpl      = 1'b1;
                    cmpl_err  = 1'b1;
                    cmpl_data = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                // Not re-arbitrating here keeps the finishing requester's stale PSEL from winning again.
                sready_d  = '0;
                sslverr_d = '0;
                gnt_d     = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (cmpl) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            sready_d  = gnt_q;
            sslverr_d = gnt_q & {2{cmpl_err}};
            sprdata_d = cmpl_data;
            last_d    = gnt_q[1];
            state_d   = ST_DONE;
        end
    end

    assign bus.GNT       = gnt_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PPROT     = pprot_q;
    assign bus.PSTRB     = pstrb_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.S_PREADY  = sready_q;
    assign bus.S_PSLVERR = sslverr_q;
    assign bus.S_PRDATA  = sprdata_q;
endmodule

// File: tb/tb_apb_mst_arb2.sv
// Testbench for apb_mst_arb2: directed latency/reset/timeout scenarios, then random traffic
// checked against a transaction-level round-robin model. Honours APB_MST_ARB2_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_apb_mst_arb2;
    localparam int NTX = 60;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    apb_mst_arb2_if #(.PADDR_SIZE(10), .PDATA_SIZE(8)) bus ();

    apb_mst_arb2 #(.PADDR_SIZE(10), .PDATA_SIZE(8), .TIMEOUT(16)) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input int i, input logic wr, input logic [9:0] a,
                             input logic [7:0] d, input logic s, input logic [2:0] p);
        bus.S_PWRITE[i] = wr;
        bus.S_PADDR[i]  = a;
        bus.S_PWDATA[i] = d;
        bus.S_PSTRB[i]  = s;
        bus.S_PPROT[i]  = p;
        bus.S_PSEL[i]   = 1'b1;
    endtask

    function automatic logic [31:0] onehot(input int g);
        return (g == 1) ? 32'h2 : 32'h1;
    endfunction

    // Random-phase model state
    bit             active [2];
    logic [9:0]     t_addr [2];
    logic [7:0]     t_data [2];
    logic           t_wr   [2];
    logic           t_strb [2];
    logic [2:0]     t_prot [2];
    logic [1:0]     req_seen, exp_rdy, exp_next, exp_err, exp_gnt;
    logic [7:0]     exp_rd;
    bit             last;
    int             cur_g, wait_left, issued, done;

    initial begin
        bus.S_PSEL = '0; bus.S_PENABLE = '0; bus.S_PWRITE = '0; bus.S_PPROT = '0;
        bus.S_PSTRB = '0; bus.S_PADDR = '0; bus.S_PWDATA = '0;
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
        #1 rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_psel", bus.PSEL, 0);
        check("rst_penable", bus.PENABLE, 0);
        check("rst_gnt", bus.GNT, 0);
        check("rst_sready", bus.S_PREADY, 0);
        check("rst_sprdata", bus.S_PRDATA, 0);
        check("rst_paddr", bus.PADDR, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Req0 write, PREADY high: PSEL at N+1, PENABLE at N+2, S_PREADY at N+3
        drive_req(0, 1'b1, 10'h012, 8'hA5, 1'b1, 3'b000);
        bus.PREADY = 1'b1; bus.PRDATA = 8'h77; bus.PSLVERR = 1'b0;
        @(negedge clk);
        check("wr_psel", bus.PSEL, 1);
        check("wr_penable0", bus.PENABLE, 0);
        check("wr_gnt", bus.GNT, 2'b01);
        check("wr_fields", {bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PWRITE}, {10'h012, 8'hA5, 1'b1, 1'b1});
        @(negedge clk);
        check("wr_penable1", bus.PENABLE, 1);
        check("wr_sready_early", bus.S_PREADY, 0);
        @(negedge clk);
        check("wr_sready", bus.S_PREADY, 2'b01);
        check("wr_slverr", bus.S_PSLVERR, 0);
        check("wr_psel_drop", bus.PSEL, 0);
        bus.S_PSEL = '0; bus.PREADY = 1'b0;
        @(negedge clk);
        check("wr_done_clr", {bus.S_PREADY, bus.GNT}, 0);

        // Req1 read with three wait states and an error response
        drive_req(1, 1'b0, 10'h155, 8'h00, 1'b1, 3'b010);
        @(negedge clk);
        check("rd_gnt", bus.GNT, 2'b10);
        check("rd_fields", {bus.PADDR, bus.PWRITE, bus.PPROT}, {10'h155, 1'b0, 3'b010});
        @(negedge clk);
        check("rd_penable", bus.PENABLE, 1);
        for (int k = 0; k < 3; k++) begin
            bus.PRDATA = 8'($urandom);
            @(negedge clk);
            check("rd_wait", {bus.PSEL, bus.PENABLE, bus.S_PREADY}, 4'b1100);
        end
        bus.PREADY = 1'b1; bus.PRDATA = 8'h3C; bus.PSLVERR = 1'b1;
        @(negedge clk);
        check("rd_sready", bus.S_PREADY, 2'b10);
        check("rd_slverr", bus.S_PSLVERR, 2'b10);
        check("rd_prdata", bus.S_PRDATA, 8'h3C);
        bus.S_PSEL = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        @(negedge clk);
        check("rd_one_cycle", {bus.S_PREADY, bus.S_PSLVERR}, 0);
        check("rd_prdata_hold", bus.S_PRDATA, 8'h3C);

        // PREADY stuck low
        drive_req(0, 1'b1, 10'h3FF, 8'h5A, 1'b1, 3'b001);
        @(negedge clk);
        @(negedge clk);
`ifdef APB_MST_ARB2_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("to_wait", {bus.PSEL, bus.S_PREADY}, 3'b100);
        end
        @(negedge clk);
        check("to_psel", bus.PSEL, 0);
        check("to_sready", bus.S_PREADY, 2'b01);
        check("to_slverr", bus.S_PSLVERR, 2'b01);
        check("to_prdata", bus.S_PRDATA, 0);
        bus.S_PSEL = '0;
        @(negedge clk);
        drive_req(0, 1'b1, 10'h3FF, 8'h5A, 1'b1, 3'b001);
        repeat (3) @(negedge clk);
`else
        repeat (100) @(negedge clk);
        check("stuck_psel_en", {bus.PSEL, bus.PENABLE}, 2'b11);
        check("stuck_sready", bus.S_PREADY, 0);
`endif

        // Asynchronous reset in ACCESS, then both requesting
        check("pre_rst_access", bus.PENABLE, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outs", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PPROT, bus.PSTRB, bus.PADDR}, 0);
        check("arst_resp", {bus.PWDATA, bus.S_PREADY, bus.S_PSLVERR, bus.S_PRDATA, bus.GNT}, 0);
        drive_req(0, 1'b1, 10'h001, 8'h11, 1'b1, 3'b000);
        drive_req(1, 1'b1, 10'h002, 8'h22, 1'b1, 3'b000);
        bus.PREADY = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) check("rr_g1", bus.GNT, 2'b01);
            if (k == 3) check("rr_sready0", bus.S_PREADY, 2'b01);
            if (k == 5) check("rr_g2", bus.GNT, 2'b10);
            if (k == 7) check("rr_sready1", bus.S_PREADY, 2'b10);
            if (k == 9) check("rr_g3", bus.GNT, 2'b01);
        end

        // Clean restart for random traffic
        bus.S_PSEL = '0; bus.PREADY = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        last = 1'b1; cur_g = 0; exp_rdy = '0; exp_err = '0; exp_rd = '0; req_seen = '0;
        wait_left = $urandom_range(3); issued = 0; done = 0;
        active[0] = 1'b0; active[1] = 1'b0;
        for (int cyc = 0; cyc < 5000 && done < NTX; cyc++) begin
            @(negedge clk);
            check("rnd_sready", bus.S_PREADY, exp_rdy);
            check("rnd_slverr", bus.S_PSLVERR, exp_err);
            check("rnd_prdata", bus.S_PRDATA, exp_rd);
            if (exp_rdy != 0) done++;
            if (bus.PSEL && !bus.PENABLE) begin
                // Fresh grant: expected winner from the requests seen at the arbitration edge
                exp_gnt = 2'b00;
                case (req_seen)
                    2'b01: begin cur_g = 0; exp_gnt = 2'b01; end
                    2'b10: begin cur_g = 1; exp_gnt = 2'b10; end
                    2'b11: begin cur_g = last ? 0 : 1; exp_gnt = 2'(onehot(cur_g)); end
                    default: ;
                endcase
                check("rnd_grant", bus.GNT, exp_gnt);
            end
            if (bus.PSEL) begin
                check("rnd_gnt_busy", bus.GNT, onehot(cur_g));
                check("rnd_fields", {bus.PADDR, bus.PWDATA, bus.PWRITE, bus.PSTRB, bus.PPROT},
                      {t_addr[cur_g], t_data[cur_g], t_wr[cur_g], t_strb[cur_g], t_prot[cur_g]});
            end else begin
                check("rnd_gnt_idle", bus.GNT, exp_rdy);
            end

            for (int i = 0; i < 2; i++) begin
                if (exp_rdy[i]) begin
                    active[i] = 1'b0;
                    bus.S_PSEL[i] = 1'b0;
                end
                if (active[i] && bus.PSEL && bus.GNT[i]) begin
                    bus.S_PADDR[i]  = 10'($urandom);
                    bus.S_PWDATA[i] = 8'($urandom);
                    bus.S_PWRITE[i] = 1'($urandom);
                    bus.S_PPROT[i]  = 3'($urandom);
                end
                if (!active[i] && issued < NTX && $urandom_range(2) == 0) begin
                    t_addr[i] = 10'($urandom); t_data[i] = 8'($urandom);
                    t_wr[i] = 1'($urandom); t_strb[i] = 1'($urandom); t_prot[i] = 3'($urandom);
                    drive_req(i, t_wr[i], t_addr[i], t_data[i], t_strb[i], t_prot[i]);
                    active[i] = 1'b1;
                    issued++;
                end
            end
            req_seen = bus.S_PSEL;

            exp_next = '0;
            bus.PRDATA = 8'($urandom);
            bus.PSLVERR = 1'($urandom);
            if (bus.PSEL && bus.PENABLE) begin
                if (wait_left == 0) begin
                    bus.PREADY = 1'b1;
                    exp_next = 2'(onehot(cur_g));
                    exp_rd = bus.PRDATA;
                    last = (cur_g == 1);
                    wait_left = $urandom_range(3);
                end else begin
                    bus.PREADY = 1'b0;
                    wait_left--;
                end
            end else begin
                bus.PREADY = 1'($urandom);
            end
            exp_err = bus.PSLVERR ? exp_next : 2'b00;
            exp_rdy = exp_next;
        end
        check("rnd_all_done", done, NTX);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
